// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Streams a DEPTH-word program image into the CPU program memory,
//            then verifies a trailing modulo-2**DATA_W checksum word.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   loaded_count,
  output logic              done,
  output logic              error,
  output logic              cpu_run
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_depth     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sum;
  logic              w_xfer;
  logic              w_clear;
  logic              w_load_xfer;

  assign w_xfer = in_valid && in_ready;

  // start overrides everything, including a word presented in the same cycle
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_load_xfer  = 1'b0;
    if (start) begin
      w_state_next = S_LOAD;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            w_load_xfer = 1'b1;
            if (r_addr == c_last_addr) w_state_next = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_xfer) w_state_next = (in_data == r_sum) ? S_DONE : S_ERROR;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Status outputs are decoded from the next state so they line up with r_state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_run  <= 1'b0;
    end else begin
      in_ready <= (w_state_next == S_LOAD) || (w_state_next == S_CHECK);
      done     <= (w_state_next == S_DONE);
      error    <= (w_state_next == S_ERROR);
      cpu_run  <= (w_state_next == S_DONE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= w_load_xfer;
      if (w_load_xfer) begin
        mem_addr  <= r_addr;
        mem_wdata <= in_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr       <= '0;
      r_sum        <= '0;
      loaded_count <= '0;
    end else if (w_clear) begin
      r_addr       <= '0;
      r_sum        <= '0;
      loaded_count <= '0;
    end else if (w_load_xfer) begin
      r_addr <= r_addr + c_addr_one;
      r_sum  <= r_sum + in_data;
      if (loaded_count != c_depth) loaded_count <= loaded_count + c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Vector-table and directed-sequence bench for program_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] loaded_count;
  logic       done;
  logic       error;
  logic       cpu_run;

  int checks   = 0;
  int failures = 0;

  program_loader #(.DATA_W(4), .ADDR_W(3), .DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .loaded_count (loaded_count),
    .done         (done),
    .error        (error),
    .cpu_run      (cpu_run)
  );

  always #5 clock = ~clock;

  // {mem_we, mem_addr, mem_wdata, loaded_count, in_ready, done, error, cpu_run}
  typedef struct {
    logic        st;
    logic        vld;
    logic [3:0]  dat;
    logic [15:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] la = 3'd0;
  logic [3:0] lw = 4'd0;

  function automatic logic [15:0] pk(input logic we, input logic [2:0] a, input logic [3:0] wd,
                                     input logic [3:0] cnt, input logic rdy, input logic dn,
                                     input logic er, input logic run);
    return {we, a, wd, cnt, rdy, dn, er, run};
  endfunction

  task automatic push(input logic st, input logic vld, input logic [3:0] dat, input logic [15:0] exp);
    vec_t v;
    v.st = st; v.vld = vld; v.dat = dat; v.exp = exp;
    vecs.push_back(v);
  endtask

  // start, eight words, checksum, one idle cycle
  task automatic add_image(input logic [31:0] ws, input logic [3:0] cs, input logic ok);
    logic [3:0] w;
    push(1'b1, 1'b0, 4'd0, pk(1'b0, la, lw, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      w = ws[4*i +: 4];
      push(1'b0, 1'b1, w, pk(1'b1, 3'(i), w, 4'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0));
      la = 3'(i);
      lw = w;
    end
    push(1'b0, 1'b1, cs, pk(1'b0, la, lw, 4'd8, 1'b0, ok, !ok, ok));
    push(1'b0, 1'b0, 4'd0, pk(1'b0, la, lw, 4'd8, 1'b0, ok, !ok, ok));
  endtask

  task automatic step(input logic st, input logic vld, input logic [3:0] dat);
    @(negedge clock);
    start    = st;
    in_valid = vld;
    in_data  = dat;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] got;
    got = {mem_we, mem_addr, mem_wdata, loaded_count, in_ready, done, error, cpu_run};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got={we,addr,wdata,cnt,rdy,done,err,run}=%h required=%h", name, got, exp);
    end
  endtask

  initial begin
    // Table: correct image, bad checksum, all-0xF image with wrapped sum
    add_image(32'h8765_4321, 4'd4, 1'b1);
    add_image(32'h8765_4321, 4'd5, 1'b0);
    add_image(32'hFFFF_FFFF, 4'd8, 1'b1);

    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    step(1'b0, 1'b1, 4'd9);
    check("idle_ignores_valid", 16'h0000);

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].vld, vecs[i].dat);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // in_valid pattern 1,0,0 during LOAD; words 0..7 sum to 28 -> 12
    step(1'b1, 1'b0, 4'd0);
    check("gap_start", pk(1'b0, 3'd7, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'(i));
      check($sformatf("gap_xfer%0d", i), pk(1'b1, 3'(i), 4'(i), 4'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0));
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'b0, 4'hA);
        check($sformatf("gap_idle%0d_%0d", i, g), pk(1'b0, 3'(i), 4'(i), 4'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0));
      end
    end
    step(1'b0, 1'b1, 4'd12);
    check("gap_done", pk(1'b0, 3'd7, 4'd7, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1));

    // Abort after three words; restart coincides with a presented word
    step(1'b1, 1'b0, 4'd0);
    check("abort_start", pk(1'b0, 3'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'(i + 1));
      check($sformatf("abort_w%0d", i), pk(1'b1, 3'(i), 4'(i + 1), 4'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0));
    end
    step(1'b1, 1'b1, 4'd9);
    check("abort_restart", pk(1'b0, 3'd2, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'(i + 1));
      check($sformatf("reload_w%0d", i), pk(1'b1, 3'(i), 4'(i + 1), 4'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0));
    end
    step(1'b0, 1'b1, 4'd4);
    check("reload_done", pk(1'b0, 3'd7, 4'd8, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1));

    // Asynchronous reset while a write is in flight
    step(1'b1, 1'b0, 4'd0);
    check("rst_start", pk(1'b0, 3'd7, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b1, 4'd6);
    check("rst_pre", pk(1'b1, 3'd1, 4'd6, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b1, 4'd5);
    check("rst_idle", 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
